// File: rtl/background_scroller.sv
// rtl/background_scroller.sv - tile-lane playfield with frame-synchronous river scroll (optional LANE_MARKINGS_EN road dashes)
module background_scroller #(
    parameter int H_CNT_W     = 10,
    parameter int V_CNT_W     = 10,
    parameter int H_OFFSET    = 144,
    parameter int V_OFFSET    = 35,
    parameter int TILE_W_LOG2 = 5,
    parameter int TILE_H_LOG2 = 5,
    parameter int COLS        = 20,
    parameter int ROWS        = 15,
    parameter int SCROLL_DIV  = 4,
    parameter logic [2*ROWS-1:0] ROW_MAP = 30'b00_010101010101_00_101010101010_00
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [H_CNT_W-1:0]                       h_count,
    input  logic [V_CNT_W-1:0]                       v_count,
    input  logic                                     pause,
    output logic [2:0]                               bg_r,
    output logic [2:0]                               bg_g,
    output logic [2:0]                               bg_b,
    output logic                                     bg_valid,
    output logic                                     frame_tick,
    output logic [$clog2(COLS<<TILE_W_LOG2)-1:0]     scroll_offset
);

    localparam int W     = COLS << TILE_W_LOG2;
    localparam int H     = ROWS << TILE_H_LOG2;
    localparam int OFF_W = $clog2(W);
    localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [H_CNT_W:0]   H_LO    = (H_CNT_W+1)'(H_OFFSET);
    localparam logic [H_CNT_W:0]   H_HI    = (H_CNT_W+1)'(H_OFFSET + W);
    localparam logic [V_CNT_W:0]   V_LO    = (V_CNT_W+1)'(V_OFFSET);
    localparam logic [V_CNT_W:0]   V_HI    = (V_CNT_W+1)'(V_OFFSET + H);
    localparam logic [V_CNT_W-1:0] V_TICK  = V_CNT_W'(V_OFFSET + H);
    localparam logic [OFF_W:0]     W_EXT   = (OFF_W+1)'(W);
    localparam logic [OFF_W-1:0]   OFF_MAX = OFF_W'(W - 1);
    localparam logic [DIV_W-1:0]   DIV_MAX = DIV_W'(SCROLL_DIV - 1);

    localparam logic [8:0] C_GRASS = 9'b000_111_000;
    localparam logic [8:0] C_WATER = 9'b000_000_111;
    localparam logic [8:0] C_HILITE = 9'b000_011_111;

    logic [H_CNT_W-1:0] x;
    logic [V_CNT_W-1:0] y;
    logic [V_CNT_W-1:0] row;
    logic [1:0]         lane;
    logic               active;
    logic               tick_cond;
    logic [OFF_W:0]     xs_sum;
    logic [OFF_W-1:0]   xs;
    logic [8:0]         rgb_next;
    logic [DIV_W-1:0]   frame_div;
`ifdef LANE_MARKINGS_EN
    localparam logic [2*ROWS+1:0] MAP_EXT = {2'b11, ROW_MAP};
    logic [1:0]         next_lane;
`endif

    // Pixel classification: active window, lane lookup, scrolled river x and colour
    always_comb begin
        x         = h_count - H_CNT_W'(H_OFFSET);
        y         = v_count - V_CNT_W'(V_OFFSET);
        row       = y >> TILE_H_LOG2;
        active    = ({1'b0, h_count} >= H_LO) && ({1'b0, h_count} < H_HI) &&
                    ({1'b0, v_count} >= V_LO) && ({1'b0, v_count} < V_HI);
        tick_cond = (h_count == '0) && (v_count == V_TICK);
        lane      = 2'b11;
`ifdef LANE_MARKINGS_EN
        next_lane = 2'b11;
`endif
        for (int i = 0; i < ROWS; i++) begin
            if (row == V_CNT_W'(i)) begin
                lane = ROW_MAP[2*i +: 2];
`ifdef LANE_MARKINGS_EN
                next_lane = MAP_EXT[2*i+2 +: 2];
`endif
            end
        end
        // x < W and offset < W, so one conditional subtract is a full wrap
        xs_sum = (OFF_W+1)'(x) + {1'b0, scroll_offset};
        xs     = (xs_sum >= W_EXT) ? OFF_W'(xs_sum - W_EXT) : OFF_W'(xs_sum);
        rgb_next = '0;
        if (active) begin
            case (lane)
                2'b00: rgb_next = C_GRASS;
                2'b10: rgb_next = (xs[TILE_W_LOG2-1 -: 2] == 2'b11) ? C_HILITE : C_WATER;
                2'b01: begin
`ifdef LANE_MARKINGS_EN
                    if ((next_lane == 2'b01) && (&y[TILE_H_LOG2-1:0]) && !x[TILE_W_LOG2])
                        rgb_next = 9'b111_111_111;
`endif
                end
                default: rgb_next = '0;
            endcase
        end
    end

    // Output registers, frame tick and the frame-divided scroll counter
    always_ff @(posedge clk) begin
        if (reset) begin
            bg_r          <= '0;
            bg_g          <= '0;
            bg_b          <= '0;
            bg_valid      <= 1'b0;
            frame_tick    <= 1'b0;
            frame_div     <= '0;
            scroll_offset <= '0;
        end else begin
            bg_r       <= rgb_next[8:6];
            bg_g       <= rgb_next[5:3];
            bg_b       <= rgb_next[2:0];
            bg_valid   <= active;
            frame_tick <= tick_cond;
            if (tick_cond && !pause) begin
                if (frame_div == DIV_MAX) begin
                    frame_div     <= '0;
                    scroll_offset <= (scroll_offset == OFF_MAX) ? '0 : scroll_offset + 1'b1;
                end else begin
                    frame_div <= frame_div + 1'b1;
                end
            end
        end
    end

endmodule
